// File: rtl/fpu_pkg.sv
// Shared constants, opcode encoding and decoded-field layout for the FPU decode stage.
package fpu_pkg;

  localparam int REG_W = 5;
  localparam int OP_W  = 2;
  localparam int ISIZE = 3 * REG_W + OP_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } fpu_op_e;

  typedef struct packed {
    logic [REG_W-1:0] rl;
    logic [REG_W-1:0] rr;
    logic [REG_W-1:0] rd;
    fpu_op_e          op;
  } fpu_fields_t;

  // Instruction layout is RL | RR | RD | Op from MSB to LSB, so a straight cast suffices.
  function automatic fpu_fields_t fpu_extract(input logic [ISIZE-1:0] inst);
    return fpu_fields_t'(inst);
  endfunction

endpackage

// File: rtl/fpu_decode_stage_scoreboard.sv
// In-flight destination scoreboard: set on issue, clear on writeback (set wins),
// with a 3-port lookup that bypasses a same-cycle writeback.
module fpu_scoreboard #(
  parameter int REG_W = fpu_pkg::REG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en_i,
  input  logic [REG_W-1:0]      set_idx_i,
  input  logic                  clr_en_i,
  input  logic [REG_W-1:0]      clr_idx_i,
  input  logic [REG_W-1:0]      rl_i,
  input  logic [REG_W-1:0]      rr_i,
  input  logic [REG_W-1:0]      rd_i,
  output logic                  busy_rl_o,
  output logic                  busy_rr_o,
  output logic                  busy_rd_o,
  output logic [2**REG_W-1:0]   pending_o
);

  localparam int NREG = 2 ** REG_W;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) begin
      pending_d[clr_idx_i] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (set_en_i) begin
      pending_d[set_idx_i] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= {NREG{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign busy_rl_o = pending_q[rl_i] & ~(clr_en_i & (clr_idx_i == rl_i));
  assign busy_rr_o = pending_q[rr_i] & ~(clr_en_i & (clr_idx_i == rr_i));
  assign busy_rd_o = pending_q[rd_i] & ~(clr_en_i & (clr_idx_i == rd_i));
  assign pending_o = pending_q;

endmodule

// File: rtl/fpu_decode_stage.sv
// Registered FPU decode stage: splits the instruction into RL/RR/RD/Op, holds it in one
// output slot with valid/ready on both sides, and stalls issue on RAW/WAW hazards.
module fpu_decode_stage #(
  parameter int REG_W = fpu_pkg::REG_W,
  parameter int OP_W  = fpu_pkg::OP_W,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3*REG_W+OP_W-1:0]    in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REG_W-1:0]           out_rl,
  output logic [REG_W-1:0]           out_rr,
  output logic [REG_W-1:0]           out_rd,
  output logic [OP_W-1:0]            out_op,
  input  logic                       wb_valid,
  input  logic [REG_W-1:0]           wb_rd,
  input  logic                       flush,
  output logic [2**REG_W-1:0]        pending,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int ISIZE = 3 * REG_W + OP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [REG_W-1:0] in_rl, in_rr, in_rd;
  logic [OP_W-1:0]  in_op;
  logic             busy_rl, busy_rr, busy_rd;
  logic             hazard, in_fire, out_fire;

  logic             valid_q, valid_d;
  logic [REG_W-1:0] rl_q, rl_d, rr_q, rr_d, rd_q, rd_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign in_rl = in_inst[ISIZE-1 -: REG_W];
  assign in_rr = in_inst[ISIZE-1-REG_W -: REG_W];
  assign in_rd = in_inst[OP_W+REG_W-1 -: REG_W];
  assign in_op = in_inst[OP_W-1:0];

  fpu_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (out_fire),
    .set_idx_i (rd_q),
    .clr_en_i  (wb_valid),
    .clr_idx_i (wb_rd),
    .rl_i      (in_rl),
    .rr_i      (in_rr),
    .rd_i      (in_rd),
    .busy_rl_o (busy_rl),
    .busy_rr_o (busy_rr),
    .busy_rd_o (busy_rd),
    .pending_o (pending)
  );

  // The held instruction is not in the scoreboard yet, so its RD is matched separately.
  assign hazard = in_valid & (busy_rl | busy_rr | busy_rd |
                              (valid_q & ((rd_q == in_rl) | (rd_q == in_rr) | (rd_q == in_rd))));
  assign in_ready = (~valid_q | out_ready) & ~hazard & ~flush;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  always_comb begin
    valid_d = valid_q;
    rl_d    = rl_q;
    rr_d    = rr_q;
    rd_d    = rd_q;
    op_d    = op_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_fire) begin
      valid_d = 1'b1;
      rl_d    = in_rl;
      rr_d    = in_rr;
      rd_d    = in_rd;
      op_d    = in_op;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (hazard && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rl_q    <= {REG_W{1'b0}};
      rr_q    <= {REG_W{1'b0}};
      rd_q    <= {REG_W{1'b0}};
      op_q    <= {OP_W{1'b0}};
      stall_q <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      rl_q    <= rl_d;
      rr_q    <= rr_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid = valid_q;
  assign out_rl    = rl_q;
  assign out_rr    = rr_q;
  assign out_rd    = rd_q;
  assign out_op    = op_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fpu_decode_stage.sv
// Directed vector table plus randomized traffic checked against a register-busy model.
module tb_fpu_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, wb_valid, flush;
  logic [16:0] in_inst;
  logic [4:0]  wb_rd;
  logic        in_ready, out_valid, in_ready2, out_valid2;
  logic [4:0]  out_rl, out_rr, out_rd, out_rl2, out_rr2, out_rd2;
  logic [1:0]  out_op, out_op2;
  logic [31:0] pending, pending2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: which registers are issued-but-not-retired, what is held, stall count
  bit [31:0] m_pend;
  bit        m_ov;
  int        m_rl, m_rr, m_rd, m_op;
  int        m_stall;

  always #5 clk = ~clk;

  fpu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_rl(out_rl), .out_rr(out_rr),
    .out_rd(out_rd), .out_op(out_op), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  fpu_decode_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_inst(in_inst),
    .out_valid(out_valid2), .out_ready(out_ready), .out_rl(out_rl2), .out_rr(out_rr2),
    .out_rd(out_rd2), .out_op(out_op2), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .pending(pending2), .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit busy(int x);
    return (m_pend[x] && !(wb_valid && int'(wb_rd) == x)) || (m_ov && m_rd == x);
  endfunction

  function automatic logic [16:0] mk(int rl, int rr, int rd, int op);
    return 17'((rl << 12) + (rr << 7) + (rd << 2) + op);
  endfunction

  // Inputs already driven; checks in_ready before the edge, then model and registers after.
  task automatic step(input bit chk_rdy, output logic rdy_seen);
    int  rl, rr, rd, op;
    bit  haz, rdy, ofire, ifire;
    #1;
    rl  = (int'(in_inst) >> 12) % 32;
    rr  = (int'(in_inst) >> 7) % 32;
    rd  = (int'(in_inst) >> 2) % 32;
    op  = int'(in_inst) % 4;
    haz = in_valid && (busy(rl) || busy(rr) || busy(rd));
    rdy = (!m_ov || out_ready) && !haz && !flush;
    rdy_seen = in_ready;
    if (chk_rdy) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
      chk("in_ready_sat", {63'd0, in_ready2}, {63'd0, rdy});
    end
    ofire = m_ov && out_ready;
    ifire = in_valid && rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      m_pend = 32'd0; m_ov = 1'b0; m_rl = 0; m_rr = 0; m_rd = 0; m_op = 0; m_stall = 0;
    end else begin
      if (wb_valid) m_pend[wb_rd] = 1'b0;
      if (ofire) m_pend[m_rd] = 1'b1;
      if (haz) m_stall++;
      if (flush) m_ov = 1'b0;
      else if (ifire) begin
        m_ov = 1'b1; m_rl = rl; m_rr = rr; m_rd = rd; m_op = op;
      end else if (ofire) m_ov = 1'b0;
    end
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    chk("out_fields", {44'd0, out_rl, out_rr, out_rd, out_op},
        {44'd0, 5'(m_rl), 5'(m_rr), 5'(m_rd), 2'(m_op)});
    chk("pending", {32'd0, pending}, {32'd0, m_pend});
    chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall > 65535 ? 65535 : m_stall));
    chk("stall_cnt_sat", {62'd0, stall_cnt2}, 64'(m_stall > 3 ? 3 : m_stall));
  endtask

  typedef struct {
    logic        rst, in_valid;
    logic [16:0] inst;
    logic        out_ready, wb_valid;
    logic [4:0]  wb_rd;
    logic        flush, chk_rdy, exp_rdy, exp_ov;
    logic [4:0]  exp_rd;
    logic [31:0] exp_pend;
    int          exp_stall;
  } vec_t;

  vec_t vecs[21];

  initial begin
    logic rdy_seen;
    logic [16:0] i_raw, i_ind, i_r7, i_r9;
    rst = 1'b1; in_valid = 1'b0; in_inst = 17'd0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    m_pend = 32'd0; m_ov = 1'b0; m_rl = 0; m_rr = 0; m_rd = 0; m_op = 0; m_stall = 0;

    i_raw = mk(3, 4, 5, 0);
    i_ind = mk(10, 11, 12, 1);
    i_r7  = mk(13, 14, 7, 3);
    i_r9  = mk(0, 1, 9, 0);
    //            rst   iv    inst       ordy  wbv   wbrd   fl    chk   rdy   ov    rd     pend           stall
    vecs[0]  = '{1'b1, 1'b0, 17'h0,     1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         0};
    vecs[1]  = '{1'b0, 1'b1, 17'h110E,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  32'h0,         0};
    vecs[2]  = '{1'b0, 1'b1, i_raw,     1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd3,  32'h8,         1};
    vecs[3]  = '{1'b0, 1'b1, i_raw,     1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd3,  32'h8,         2};
    vecs[4]  = '{1'b0, 1'b1, i_raw,     1'b1, 1'b1, 5'd3,  1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  32'h0,         2};
    vecs[5]  = '{1'b0, 1'b1, i_ind,     1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0,         2};
    vecs[6]  = '{1'b0, 1'b1, i_ind,     1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0,         2};
    vecs[7]  = '{1'b0, 1'b1, i_ind,     1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0,         2};
    vecs[8]  = '{1'b0, 1'b1, i_ind,     1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0,         2};
    vecs[9]  = '{1'b0, 1'b1, i_ind,     1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h20,        2};
    vecs[10] = '{1'b0, 1'b1, i_r7,      1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  32'h1020,      2};
    vecs[11] = '{1'b0, 1'b0, 17'h0,     1'b1, 1'b1, 5'd7,  1'b0, 1'b1, 1'b1, 1'b0, 5'd7,  32'h10A0,      2};
    vecs[12] = '{1'b0, 1'b1, i_r9,      1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'h10A0,      2};
    vecs[13] = '{1'b0, 1'b0, 17'h0,     1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 5'd9,  32'h10A0,      2};
    vecs[14] = '{1'b0, 1'b1, 17'h0,     1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd0,  32'h10A0,      2};
    vecs[15] = '{1'b0, 1'b1, 17'h0,     1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h10A1,      3};
    vecs[16] = '{1'b0, 1'b1, 17'h0,     1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 5'd0,  32'h10A0,      3};
    vecs[17] = '{1'b0, 1'b1, 17'h0,     1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  32'h10A0,      4};
    vecs[18] = '{1'b0, 1'b1, 17'h0,     1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  32'h10A0,      5};
    vecs[19] = '{1'b0, 1'b1, 17'h0,     1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  32'h10A0,      6};
    vecs[20] = '{1'b1, 1'b1, 17'h0,     1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,         0};

    for (int v = 0; v < 21; v++) begin
      rst = vecs[v].rst; in_valid = vecs[v].in_valid; in_inst = vecs[v].inst;
      out_ready = vecs[v].out_ready; wb_valid = vecs[v].wb_valid;
      wb_rd = vecs[v].wb_rd; flush = vecs[v].flush;
      step(vecs[v].chk_rdy, rdy_seen);
      if (vecs[v].chk_rdy) chk("tbl_in_ready", {63'd0, rdy_seen}, {63'd0, vecs[v].exp_rdy});
      chk("tbl_out_valid", {63'd0, out_valid}, {63'd0, vecs[v].exp_ov});
      chk("tbl_out_rd", {59'd0, out_rd}, {59'd0, vecs[v].exp_rd});
      chk("tbl_pending", {32'd0, pending}, {32'd0, vecs[v].exp_pend});
      chk("tbl_stall", {48'd0, stall_cnt}, 64'(vecs[v].exp_stall));
    end

    // randomized traffic over a small register window so hazards are frequent
    for (int c = 0; c < 3000; c++) begin
      bit found;
      int s;
      rst       = ($urandom % 600) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_inst   = mk($urandom % 8, $urandom % 8, $urandom % 8, $urandom % 4);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 32) == 0;
      found = 1'b0;
      if (m_pend != 32'd0 && ($urandom % 2) == 1) begin
        s = $urandom % 32;
        for (int k = 0; k < 32; k++) begin
          if (!found && m_pend[(s + k) % 32]) begin
            found = 1'b1;
            wb_rd = 5'((s + k) % 32);
          end
        end
      end
      if (found) wb_valid = 1'b1;
      else begin
        wb_valid = ($urandom % 8) == 0;
        wb_rd    = 5'($urandom % 8);
      end
      step(1'b1, rdy_seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
